// File: rtl/atomrvcore_pkg.sv
// Shared types and constants for the AtomRV core writeback path.
// Holds the writeback source select, load size codes, FSM states and the load legality check.
package atomrvcore_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wbu_state_e;

  // A load is legal when its size code is known and the address is naturally aligned.
  function automatic logic load_ok(input logic [2:0] func3, input logic [1:0] off);
    logic ok;
    case (func3)
      LB, LBU: ok = 1'b1;
      LH, LHU: ok = (off[0] == 1'b0);
      LW:      ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/atomrvcore_load_align.sv
// Selects the byte/half lane of a returned memory word and sign/zero extends it.
module atomrvcore_load_align
  import atomrvcore_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] rdata,
  input  logic [1:0]           addr,
  input  logic [2:0]           func3,
  output logic [DATAWIDTH-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to the load size code.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    ext    = {DATAWIDTH{1'b0}};
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (func3)
      LB:      ext = {{(DATAWIDTH-8){byte_s[7]}}, byte_s};
      LBU:     ext = {{(DATAWIDTH-8){1'b0}}, byte_s};
      LH:      ext = {{(DATAWIDTH-16){half_s[15]}}, half_s};
      LHU:     ext = {{(DATAWIDTH-16){1'b0}}, half_s};
      LW:      ext = rdata;
      default: ext = {DATAWIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/atomrvcore_wbu.sv
// Writeback unit: turns retired execute results (and completed loads) into
// single-cycle register-file writes for the decode stage.
module atomrvcore_wbu
  import atomrvcore_pkg::*;
#(
  parameter int DATAWIDTH        = 32,
  parameter int REG_ADRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT      = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        rwr_en_i,
  input  logic [REG_ADRESS_WIDTH-1:0] rd_i,
  input  logic [1:0]                  wb_sel_i,
  input  logic [2:0]                  func3_i,
  input  logic [DATAWIDTH-1:0]        alu_result_i,
  input  logic [DATAWIDTH-1:0]        pc_plus4_i,
  input  logic [DATAWIDTH-1:0]        immed_i,
  output logic                        dmem_req_o,
  output logic [DATAWIDTH-1:0]        dmem_addr_o,
  input  logic                        dmem_ack_i,
  input  logic [DATAWIDTH-1:0]        dmem_rdata_i,
  output logic                        rwr_en_o,
  output logic [REG_ADRESS_WIDTH-1:0] rd_o,
  output logic [DATAWIDTH-1:0]        wr_o,
  output logic                        load_err_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  wbu_state_e                  state_r, state_s;
  logic [CW-1:0]               cnt_r, cnt_s;
  logic                        ready_r;
  logic                        req_r, req_s;
  logic [DATAWIDTH-1:0]        addr_r, addr_s;
  logic                        rwr_en_r, rwr_en_s;
  logic [REG_ADRESS_WIDTH-1:0] rd_r, rd_s;
  logic [DATAWIDTH-1:0]        wr_r, wr_s;
  logic                        err_r, err_s;
  logic [REG_ADRESS_WIDTH-1:0] ld_rd_r, ld_rd_s;
  logic [2:0]                  ld_f3_r, ld_f3_s;
  logic [1:0]                  ld_off_r, ld_off_s;
  logic                        accept_s;
  logic [DATAWIDTH-1:0]        sel_data_s;
  logic [DATAWIDTH-1:0]        load_data_s;

  atomrvcore_load_align #(
    .DATAWIDTH(DATAWIDTH)
  ) u_load_align (
    .rdata (dmem_rdata_i),
    .addr  (ld_off_r),
    .func3 (ld_f3_r),
    .ext   (load_data_s)
  );

  // ready_r is the registered view of IDLE, so it is also 0 while in reset.
  assign accept_s = valid_i && ready_r;

  // Source mux for non-load results.
  always_comb begin
    sel_data_s = alu_result_i;
    case (wb_sel_i)
      WB_ALU:  sel_data_s = alu_result_i;
      WB_PC4:  sel_data_s = pc_plus4_i;
      WB_IMM:  sel_data_s = immed_i;
      default: sel_data_s = alu_result_i;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    req_s    = req_r;
    addr_s   = addr_r;
    rwr_en_s = 1'b0;
    rd_s     = rd_r;
    wr_s     = wr_r;
    err_s    = 1'b0;
    ld_rd_s  = ld_rd_r;
    ld_f3_s  = ld_f3_r;
    ld_off_s = ld_off_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CW{1'b0}};
        req_s = 1'b0;
        if (accept_s) begin
          if (wb_sel_i == WB_LOAD) begin
            if (load_ok(func3_i, alu_result_i[1:0])) begin
              state_s  = ST_MEM_WAIT;
              req_s    = 1'b1;
              addr_s   = {alu_result_i[DATAWIDTH-1:2], 2'b00};
              ld_rd_s  = rd_i;
              ld_f3_s  = func3_i;
              ld_off_s = alu_result_i[1:0];
            end else begin
              err_s = 1'b1;
            end
          end else begin
            rwr_en_s = rwr_en_i && (rd_i != {REG_ADRESS_WIDTH{1'b0}});
            rd_s     = rd_i;
            wr_s     = sel_data_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        // An ack on the expiry cycle is checked first, so it still completes the load.
        if (dmem_ack_i) begin
          state_s  = ST_IDLE;
          req_s    = 1'b0;
          cnt_s    = {CW{1'b0}};
          rwr_en_s = (ld_rd_r != {REG_ADRESS_WIDTH{1'b0}});
          rd_s     = ld_rd_r;
          wr_s     = load_data_s;
        end else if (cnt_r == CW'(MEM_TIMEOUT - 1)) begin
          state_s = ST_IDLE;
          req_s   = 1'b0;
          cnt_s   = {CW{1'b0}};
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      ready_r  <= 1'b0;
      req_r    <= 1'b0;
      addr_r   <= {DATAWIDTH{1'b0}};
      rwr_en_r <= 1'b0;
      rd_r     <= {REG_ADRESS_WIDTH{1'b0}};
      wr_r     <= {DATAWIDTH{1'b0}};
      err_r    <= 1'b0;
      ld_rd_r  <= {REG_ADRESS_WIDTH{1'b0}};
      ld_f3_r  <= 3'b000;
      ld_off_r <= 2'b00;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ready_r  <= (state_s == ST_IDLE);
      req_r    <= req_s;
      addr_r   <= addr_s;
      rwr_en_r <= rwr_en_s;
      rd_r     <= rd_s;
      wr_r     <= wr_s;
      err_r    <= err_s;
      ld_rd_r  <= ld_rd_s;
      ld_f3_r  <= ld_f3_s;
      ld_off_r <= ld_off_s;
    end
  end

  assign ready_o     = ready_r;
  assign dmem_req_o  = req_r;
  assign dmem_addr_o = addr_r;
  assign rwr_en_o    = rwr_en_r;
  assign rd_o        = rd_r;
  assign wr_o        = wr_r;
  assign load_err_o  = err_r;

endmodule

// File: tb/tb_atomrvcore_wbu.sv
// Directed and randomized bench for atomrvcore_wbu against a behavioural load/writeback model.
module tb_atomrvcore_wbu;

  localparam int TMO = 15;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        rwr_en_i = 1'b0;
  logic [4:0]  rd_i = 5'd0;
  logic [1:0]  wb_sel_i = 2'd0;
  logic [2:0]  func3_i = 3'd0;
  logic [31:0] alu_result_i = 32'd0;
  logic [31:0] pc_plus4_i = 32'd0;
  logic [31:0] immed_i = 32'd0;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'd0;
  logic        rwr_en_o;
  logic [4:0]  rd_o;
  logic [31:0] wr_o;
  logic        load_err_o;

  int checks = 0;
  int errors = 0;

  atomrvcore_wbu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .rwr_en_i(rwr_en_i), .rd_i(rd_i), .wb_sel_i(wb_sel_i), .func3_i(func3_i),
    .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .immed_i(immed_i),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .rwr_en_o(rwr_en_o), .rd_o(rd_o), .wr_o(wr_o),
    .load_err_o(load_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                       input logic we);
    valid_i = 1'b1; wb_sel_i = sel; rd_i = rd; func3_i = f3;
    alu_result_i = alu; pc_plus4_i = pc; immed_i = imm; rwr_en_i = we;
  endtask

  // Load legality from the size code: known sizes only, naturally aligned.
  function automatic bit model_legal(input logic [2:0] f3, input logic [1:0] off);
    int nbytes;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (int'(off) % nbytes) == 0;
  endfunction

  // Loaded value: shift the lane down, mask to size, subtract 2^n when signed and negative.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    int nbytes;
    longint unsigned v;
    longint unsigned span;
    nbytes = 1 << f3[1:0];
    span = 64'd1 << (8 * nbytes);
    v = (64'(rdata) >> (8 * int'(off))) % span;
    if (!f3[2] && nbytes < 4 && v >= (span >> 1)) v = v - span;
    return v[31:0];
  endfunction

  initial begin
    #20000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_rwr", 32'(rwr_en_o), 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_wr", wr_o, 32'd0);
    chk("rst_err", 32'(load_err_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    chk("idle_ready", 32'(ready_o), 32'd1);

    // ALU writeback
    drive(2'd0, 5'd5, 3'd0, 32'h0000_00AA, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("alu_rwr", 32'(rwr_en_o), 32'd1);
    chk("alu_rd", 32'(rd_o), 32'd5);
    chk("alu_wr", wr_o, 32'h0000_00AA);
    chk("alu_ready", 32'(ready_o), 32'd1);
    tick();
    chk("alu_single_pulse", 32'(rwr_en_o), 32'd0);

    // x0 suppression and back-to-back writes
    drive(2'd0, 5'd0, 3'd0, 32'h1111_1111, 32'h0, 32'h0, 1'b1);
    tick();
    chk("x0_rwr", 32'(rwr_en_o), 32'd0);
    drive(2'd2, 5'd7, 3'd0, 32'h0, 32'h0000_0104, 32'h0, 1'b1);
    tick();
    chk("b2b7_rwr", 32'(rwr_en_o), 32'd1);
    chk("b2b7_rd", 32'(rd_o), 32'd7);
    chk("b2b7_wr", wr_o, 32'h0000_0104);
    drive(2'd3, 5'd8, 3'd0, 32'h0, 32'h0, 32'hABCD_E000, 1'b1);
    tick(); valid_i = 1'b0;
    chk("b2b8_rwr", 32'(rwr_en_o), 32'd1);
    chk("b2b8_rd", 32'(rd_o), 32'd8);
    chk("b2b8_wr", wr_o, 32'hABCD_E000);
    tick();
    chk("b2b_end", 32'(rwr_en_o), 32'd0);

    // LB sign extension with three wait cycles
    drive(2'd1, 5'd9, 3'b000, 32'h0000_1003, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("lb_req", 32'(dmem_req_o), 32'd1);
    chk("lb_addr", dmem_addr_o, 32'h0000_1000);
    chk("lb_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lb_wait_req", 32'(dmem_req_o), 32'd1);
      chk("lb_wait_ready", 32'(ready_o), 32'd0);
      chk("lb_wait_rwr", 32'(rwr_en_o), 32'd0);
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_1234;
    tick(); dmem_ack_i = 1'b0;
    chk("lb_rwr", 32'(rwr_en_o), 32'd1);
    chk("lb_rd", 32'(rd_o), 32'd9);
    chk("lb_wr", wr_o, 32'hFFFF_FF80);
    chk("lb_req_drop", 32'(dmem_req_o), 32'd0);
    chk("lb_ready_back", 32'(ready_o), 32'd1);
    tick();
    chk("lb_single_pulse", 32'(rwr_en_o), 32'd0);

    // LHU, then misaligned LW
    drive(2'd1, 5'd10, 3'b101, 32'h0000_2002, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("lhu_addr", dmem_addr_o, 32'h0000_2000);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBEEF_0001;
    tick(); dmem_ack_i = 1'b0;
    chk("lhu_rwr", 32'(rwr_en_o), 32'd1);
    chk("lhu_wr", wr_o, 32'h0000_BEEF);
    drive(2'd1, 5'd11, 3'b010, 32'h0000_2001, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("lw_mis_err", 32'(load_err_o), 32'd1);
    chk("lw_mis_req", 32'(dmem_req_o), 32'd0);
    chk("lw_mis_rwr", 32'(rwr_en_o), 32'd0);
    chk("lw_mis_ready", 32'(ready_o), 32'd1);
    tick();
    chk("lw_mis_err_pulse", 32'(load_err_o), 32'd0);

    // Timeout, then a late ack
    drive(2'd1, 5'd12, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("tmo_req", 32'(dmem_req_o), 32'd1);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("tmo_wait_req", 32'(dmem_req_o), 32'd1);
    end
    tick();
    chk("tmo_req_drop", 32'(dmem_req_o), 32'd0);
    chk("tmo_err", 32'(load_err_o), 32'd1);
    chk("tmo_rwr", 32'(rwr_en_o), 32'd0);
    chk("tmo_ready", 32'(ready_o), 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    tick(); dmem_ack_i = 1'b0;
    chk("tmo_late_rwr", 32'(rwr_en_o), 32'd0);
    chk("tmo_late_err", 32'(load_err_o), 32'd0);

    // Ack on the expiry cycle still completes the load
    drive(2'd1, 5'd13, 3'b010, 32'h0000_3004, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    for (int i = 1; i < TMO; i++) tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    tick(); dmem_ack_i = 1'b0;
    chk("expiry_ack_rwr", 32'(rwr_en_o), 32'd1);
    chk("expiry_ack_wr", wr_o, 32'hCAFE_F00D);
    chk("expiry_ack_err", 32'(load_err_o), 32'd0);

    // Reset in the middle of a load
    drive(2'd1, 5'd14, 3'b000, 32'h0000_4000, 32'h0, 32'h0, 1'b1);
    tick(); valid_i = 1'b0;
    chk("mrst_req_before", 32'(dmem_req_o), 32'd1);
    #2; rst_ni = 1'b0; #1;
    chk("mrst_req_now", 32'(dmem_req_o), 32'd0);
    chk("mrst_rwr_now", 32'(rwr_en_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    chk("mrst_ready", 32'(ready_o), 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0000_00FF;
    tick(); dmem_ack_i = 1'b0;
    chk("mrst_ack_rwr", 32'(rwr_en_o), 32'd0);
    chk("mrst_ack_req", 32'(dmem_req_o), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] alu, pc, imm, rdata, exp_wr;
      logic        we;
      int          d;
      sel = 2'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      alu = $urandom; pc = $urandom; imm = $urandom; rdata = $urandom;
      we  = 1'($urandom_range(0, 1));
      drive(sel, rd, f3, alu, pc, imm, we);
      if (sel != 2'd1) begin
        dmem_ack_i = 1'($urandom_range(0, 1));
        exp_wr = (sel == 2'd2) ? pc : ((sel == 2'd3) ? imm : alu);
        tick(); valid_i = 1'b0; dmem_ack_i = 1'b0;
        chk("rnd_rwr", 32'(rwr_en_o), 32'(we && (rd != 5'd0)));
        chk("rnd_req", 32'(dmem_req_o), 32'd0);
        if (we && rd != 5'd0) begin
          chk("rnd_rd", 32'(rd_o), 32'(rd));
          chk("rnd_wr", wr_o, exp_wr);
        end
      end else begin
        tick(); valid_i = 1'b0;
        if (!model_legal(f3, alu[1:0])) begin
          chk("rnd_ill_err", 32'(load_err_o), 32'd1);
          chk("rnd_ill_req", 32'(dmem_req_o), 32'd0);
          chk("rnd_ill_rwr", 32'(rwr_en_o), 32'd0);
        end else begin
          chk("rnd_ld_req", 32'(dmem_req_o), 32'd1);
          chk("rnd_ld_addr", dmem_addr_o, alu & 32'hFFFF_FFFC);
          d = $urandom_range(0, TMO + 2);
          for (int j = 0; j < TMO; j++) begin
            // Ready is low, so these offered results must be ignored.
            drive(2'd0, 5'd1, 3'd0, $urandom, 32'h0, 32'h0, 1'b1);
            valid_i = 1'($urandom_range(0, 1));
            dmem_ack_i = (j == d);
            dmem_rdata_i = (j == d) ? rdata : $urandom;
            tick(); dmem_ack_i = 1'b0; valid_i = 1'b0;
            if (j == d) begin
              chk("rnd_ld_rwr", 32'(rwr_en_o), 32'(rd != 5'd0));
              chk("rnd_ld_req_drop", 32'(dmem_req_o), 32'd0);
              if (rd != 5'd0) begin
                chk("rnd_ld_rd", 32'(rd_o), 32'(rd));
                chk("rnd_ld_wr", wr_o, model_load(rdata, alu[1:0], f3));
              end
              break;
            end else if (j == TMO - 1) begin
              chk("rnd_tmo_err", 32'(load_err_o), 32'd1);
              chk("rnd_tmo_req", 32'(dmem_req_o), 32'd0);
              chk("rnd_tmo_rwr", 32'(rwr_en_o), 32'd0);
            end else begin
              chk("rnd_wait_req", 32'(dmem_req_o), 32'd1);
              chk("rnd_wait_rwr", 32'(rwr_en_o), 32'd0);
              chk("rnd_wait_ready", 32'(ready_o), 32'd0);
            end
          end
        end
      end
    end
    valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atomrvcore_wbu.md
Name: atomrvcore_wbu

Overview:
- Writeback unit: the producer end of the decode unit's register-file write port.
- Accepts one retired result per handshake from the execute stage.
- For loads, runs a request/acknowledge read on data memory, then aligns and extends the returned byte/half/word.
- Drives a single-cycle register write (enable, destination, data) back into the decode stage's register file; stalls upstream while a load is outstanding.

Parameters:
- DATAWIDTH, 32, data/address width
- REG_ADRESS_WIDTH, 5, register index width
- MEM_TIMEOUT, 15, cycles waiting for dmem_ack_i before the load is aborted

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  execute result valid
- ready_o  out  1  unit can accept (high only in IDLE)
- rwr_en_i  in  1  instruction writes a register
- rd_i  in  REG_ADRESS_WIDTH  destination register
- wb_sel_i  in  2  source select: 0 ALU, 1 LOAD, 2 PC+4 (JAL/JALR link), 3 IMM (LUI)
- func3_i  in  3  load size/sign
- alu_result_i  in  DATAWIDTH  ALU result / load effective address
- pc_plus4_i  in  DATAWIDTH  link value
- immed_i  in  DATAWIDTH  U-type immediate
- dmem_req_o  out  1  data memory read request
- dmem_addr_o  out  DATAWIDTH  word-aligned read address
- dmem_ack_i  in  1  read data valid
- dmem_rdata_i  in  DATAWIDTH  read word
- rwr_en_o  out  1  register write strobe to decode
- rd_o  out  REG_ADRESS_WIDTH  write index
- wr_o  out  DATAWIDTH  write data
- load_err_o  out  1  one-cycle pulse on misaligned, illegal-size or timed-out load

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset is asynchronous, active-low, and may be asserted mid-load.
- FSM states: IDLE, MEM_WAIT. Outputs are registered. ready_o = (state == IDLE).
- Accept = valid_i && ready_o.
- Non-load accept (wb_sel_i != 1):
  - Next cycle: rwr_en_o = rwr_en_i && (rd_i != 0); rd_o = rd_i; wr_o = selected source.
  - Stays in IDLE, so back-to-back accepts give one write per cycle.
- Load accept, legal and aligned:
  - Latch rd, func3 and addr[1:0].
  - Next cycle: dmem_req_o = 1, dmem_addr_o = {alu_result_i[31:2], 2'b00}; enter MEM_WAIT.
  - dmem_req_o is held until dmem_ack_i is sampled high; it drops the cycle after the ack.
  - The cycle after the ack: one-cycle rwr_en_o pulse (suppressed if rd == 0) with formatted data; return to IDLE.
- Load formatting (byte lane chosen by addr[1:0]):
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half, lane addr[1].
  - 101 LHU: zero-extend half, lane addr[1].
  - 010 LW: full word.
- Load errors (no request, no write, one-cycle load_err_o pulse the next cycle, stay in IDLE):
  - func3 not in {000, 001, 010, 100, 101};
  - LH/LHU with addr[0] = 1;
  - LW with addr[1:0] != 0.
- Timeout:
  - Counter increments each MEM_WAIT cycle without ack.
  - Reaching MEM_TIMEOUT: drop dmem_req_o, pulse load_err_o, no write, return to IDLE.
  - An ack on the same cycle as expiry wins: the load completes normally.
- dmem_ack_i in IDLE is ignored; no write is produced.
- rwr_en_o is never high for two consecutive cycles from the same instruction.
- Non-write cycles: rwr_en_o = 0; rd_o and wr_o hold their last values.
- Reset during MEM_WAIT: dmem_req_o and rwr_en_o go low immediately; the pending load is discarded.

Decomposition:
- Shared package atomrvcore_pkg holds:
  - wb_sel enum (WB_ALU, WB_LOAD, WB_PC4, WB_IMM);
  - load func3 constants (LB, LH, LW, LBU, LHU);
  - FSM state enum.
- One combinational sub-module, atomrvcore_load_align: inputs rdata, addr[1:0], func3; output extended word.

Test Plan:
- ALU writeback: valid_i=1, wb_sel=0, rd=5, alu_result=0x0000_00AA -> next cycle rwr_en_o=1, rd_o=5, wr_o=0xAA; ready_o stays 1.
- x0 suppression and back-to-back: three accepts on consecutive cycles with rd=0, 7, 8 -> write pulses only for 7 and 8, on consecutive cycles.
- LB sign extension: addr=0x1003, rdata=0x80FF_1234, ack after 3 wait cycles -> dmem_addr_o=0x1000, ready_o low during wait, wr_o=0xFFFF_FF80.
- LHU and LW: LHU addr=0x2002, rdata=0xBEEF_0001 -> wr_o=0x0000_BEEF; LW addr=0x2001 -> load_err_o pulse, no dmem_req_o, no write.
- Timeout: load issued, no ack for 15 cycles -> dmem_req_o drops, load_err_o pulse, ready_o returns; a late ack produces no write.
- Mid-load reset: rst_ni low while in MEM_WAIT -> dmem_req_o=0 immediately; after release, an ack produces no write.
